// File: rtl/z80_interrupts_pkg.sv
// rtl/z80_interrupts_pkg.sv - interrupt mode type and opcode-to-mode decode
package z80_int_pkg;

   typedef enum logic [1:0] {
      IM_0 = 2'd0,
      IM_1 = 2'd1,
      IM_2 = 2'd2
   } im_t;

   // ED 46/56/5E carry the mode in opcode bits [4:3]; 00 and 01 both select IM0
   function automatic im_t db_to_im(input logic [1:0] db);
      case (db)
         2'b10:   return IM_1;
         2'b11:   return IM_2;
         default: return IM_0;
      endcase
   endfunction

endpackage

// File: rtl/z80_interrupts_if.sv
// rtl/z80_interrupts_if.sv - control/request/status bundle between sequencer and interrupt unit
interface z80_interrupts_if;
   logic       ctl_im_we;
   logic [1:0] db;
   logic       ctl_iffx_we;
   logic       ctl_iffx_bit;
   logic       ctl_iff1_iff2;
   logic       ctl_no_ints;
   logic       nmi;
   logic       intr;
   logic       setM1;
   logic       iff1;
   logic       iff2;
   logic       im1;
   logic       im2;
   logic       in_nmi;
   logic       in_intr;

   modport master (
      output ctl_im_we, db, ctl_iffx_we, ctl_iffx_bit, ctl_iff1_iff2, ctl_no_ints,
      output nmi, intr, setM1,
      input  iff1, iff2, im1, im2, in_nmi, in_intr
   );

   modport slave (
      input  ctl_im_we, db, ctl_iffx_we, ctl_iffx_bit, ctl_iff1_iff2, ctl_no_ints,
      input  nmi, intr, setM1,
      output iff1, iff2, im1, im2, in_nmi, in_intr
   );
endinterface

// File: rtl/z80_interrupts_nmi_edge_latch.sv
// rtl/z80_interrupts_nmi_edge_latch.sv - NMI rising-edge detect and pending flag (INT_SYNC_EN adds 2-flop sync)
module nmi_edge_latch (
   input  logic clk,
   input  logic nreset,
   input  logic nmi,
   input  logic take,
   output logic nmi_req
);

   logic nmi_s;
   logic nmi_prev;
   logic pending;
   logic nmi_rise;

`ifdef INT_SYNC_EN
   logic [1:0] nmi_sync;

   always_ff @(posedge clk) begin
      if (!nreset) nmi_sync <= 2'b00;
      else         nmi_sync <= {nmi_sync[0], nmi};
   end

   assign nmi_s = nmi_sync[1];
`else
   assign nmi_s = nmi;
`endif

   assign nmi_rise = nmi_s & ~nmi_prev;
   // an edge arriving on the same cycle as the boundary is served immediately
   assign nmi_req  = pending | nmi_rise;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         nmi_prev <= 1'b0;
         pending  <= 1'b0;
      end else begin
         nmi_prev <= nmi_s;
         pending  <= take ? 1'b0 : nmi_req;
      end
   end

endmodule

// File: rtl/z80_interrupts.sv
// rtl/z80_interrupts.sv - Z80 interrupt mode, IFF1/IFF2 and NMI/INT arbitration (INT_SYNC_EN syncs nmi/intr)
module z80_interrupts
   import z80_int_pkg::*;
(
   input logic               clk,
   input logic               nreset,
   z80_interrupts_if.slave   bus
);

   im_t  im_q;
   logic iff1_q, iff2_q, in_nmi_q, in_intr_q;
   logic iff1_d, iff2_d, in_nmi_d, in_intr_d;
   logic intr_s, nmi_req, take_nmi, window;

`ifdef INT_SYNC_EN
   logic [1:0] intr_sync;

   always_ff @(posedge clk) begin
      if (!nreset) intr_sync <= 2'b00;
      else         intr_sync <= {intr_sync[0], bus.intr};
   end

   assign intr_s = intr_sync[1];
`else
   assign intr_s = bus.intr;
`endif

   assign window   = bus.setM1 & ~bus.ctl_no_ints;
   assign take_nmi = window & nmi_req;

   nmi_edge_latch u_nmi (
      .clk     (clk),
      .nreset  (nreset),
      .nmi     (bus.nmi),
      .take    (take_nmi),
      .nmi_req (nmi_req)
   );

   always_comb begin
      iff1_d    = iff1_q;
      iff2_d    = iff2_q;
      in_nmi_d  = in_nmi_q;
      in_intr_d = in_intr_q;

      if (bus.ctl_iffx_we) begin
         iff1_d = bus.ctl_iffx_bit;
         iff2_d = bus.ctl_iffx_bit;
      end
      if (bus.ctl_iff1_iff2) iff1_d = iff2_q;

      // acceptance is applied last so it overrides EI/DI/RETN in the same cycle
      if (bus.setM1) begin
         in_nmi_d  = 1'b0;
         in_intr_d = 1'b0;
         if (take_nmi) begin
            in_nmi_d = 1'b1;
            iff1_d   = 1'b0;
         end else if (window && intr_s && iff1_q) begin
            in_intr_d = 1'b1;
            iff1_d    = 1'b0;
            iff2_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         im_q      <= IM_0;
         iff1_q    <= 1'b0;
         iff2_q    <= 1'b0;
         in_nmi_q  <= 1'b0;
         in_intr_q <= 1'b0;
      end else begin
         if (bus.ctl_im_we) im_q <= db_to_im(bus.db);
         iff1_q    <= iff1_d;
         iff2_q    <= iff2_d;
         in_nmi_q  <= in_nmi_d;
         in_intr_q <= in_intr_d;
      end
   end

   assign bus.iff1    = iff1_q;
   assign bus.iff2    = iff2_q;
   assign bus.im1     = (im_q == IM_1);
   assign bus.im2     = (im_q == IM_2);
   assign bus.in_nmi  = in_nmi_q;
   assign bus.in_intr = in_intr_q;

endmodule

// File: tb/tb_z80_interrupts.sv
// tb/tb_z80_interrupts.sv - randomized scoreboard bench for z80_interrupts against a rule-level model
module tb_z80_interrupts;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   z80_interrupts_if bus();

   z80_interrupts dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   // stimulus variables for the next cycle
   logic       r_nreset, r_im_we, r_iffx_we, r_iffx_bit, r_i12, r_no_ints, r_nmi, r_intr, r_m1;
   logic [1:0] r_db;

   // reference model state: mode number, enables, latched NMI, current acknowledge (0 none,1 nmi,2 int)
   int  m_mode;
   bit  m_ie1, m_ie2, m_nmi_latched, m_nmi_seen;
   int  m_ack;

   logic [5:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   task automatic idle();
      r_nreset = 1'b1; r_im_we = 1'b0; r_db = 2'b00; r_iffx_we = 1'b0; r_iffx_bit = 1'b0;
      r_i12 = 1'b0; r_no_ints = 1'b0; r_m1 = 1'b0;
   endtask

   task automatic step();
      bit rise, old_ie1, old_ie2, want_nmi, window;
      @(negedge clk);
      nreset            = r_nreset;
      bus.ctl_im_we     = r_im_we;
      bus.db            = r_db;
      bus.ctl_iffx_we   = r_iffx_we;
      bus.ctl_iffx_bit  = r_iffx_bit;
      bus.ctl_iff1_iff2 = r_i12;
      bus.ctl_no_ints   = r_no_ints;
      bus.nmi           = r_nmi;
      bus.intr          = r_intr;
      bus.setM1         = r_m1;

      if (!r_nreset) begin
         m_mode = 0; m_ie1 = 0; m_ie2 = 0; m_nmi_latched = 0; m_nmi_seen = 0; m_ack = 0;
      end else begin
         old_ie1 = m_ie1; old_ie2 = m_ie2;
         rise = r_nmi && !m_nmi_seen;
         m_nmi_seen = r_nmi;
         want_nmi = m_nmi_latched || rise;
         window = r_m1 && !r_no_ints;

         if (r_iffx_we) begin m_ie1 = r_iffx_bit; m_ie2 = r_iffx_bit; end
         if (r_i12) m_ie1 = old_ie2;

         if (r_im_we) m_mode = (r_db == 2'b11) ? 2 : (r_db == 2'b10) ? 1 : 0;

         m_nmi_latched = want_nmi;
         if (r_m1) begin
            if (window && want_nmi) begin
               m_ack = 1; m_ie1 = 0; m_nmi_latched = 0;
            end else if (window && r_intr && old_ie1) begin
               m_ack = 2; m_ie1 = 0; m_ie2 = 0;
            end else begin
               m_ack = 0;
            end
         end
      end
      exp_q.push_back({m_ie1, m_ie2, m_mode == 1, m_mode == 2, m_ack == 1, m_ack == 2});
   endtask

   // monitor: one expected vector per clocked cycle, sampled after the edge
   initial begin
      logic [5:0] got, want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {bus.iff1, bus.iff2, bus.im1, bus.im2, bus.in_nmi, bus.in_intr};
            cycle++;
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL outputs cycle %0d {iff1,iff2,im1,im2,in_nmi,in_intr} got=%b exp=%b",
                        cycle, got, want);
            end
         end
      end
   end

   initial begin
      nreset = 1'b0;
      bus.ctl_im_we = 0; bus.db = 0; bus.ctl_iffx_we = 0; bus.ctl_iffx_bit = 0;
      bus.ctl_iff1_iff2 = 0; bus.ctl_no_ints = 0; bus.nmi = 0; bus.intr = 0; bus.setM1 = 0;
      r_nmi = 0; r_intr = 0;
      idle(); r_nreset = 0; step(); step();

      // mode select
      idle(); r_im_we = 1; r_db = 2'b10; step();
      r_db = 2'b11; step();
      r_db = 2'b00; step();
      r_db = 2'b01; step();
      // RETN copy together with EI from 0/0
      idle(); r_iffx_we = 1; r_iffx_bit = 1; r_i12 = 1; step(); step();
      // DI then EI, then NMI edge followed by two boundaries
      idle(); r_iffx_we = 1; r_iffx_bit = 0; step();
      r_iffx_bit = 1; step();
      idle(); r_nmi = 1; step();
      r_m1 = 1; step();
      r_m1 = 1; step();
      idle(); r_nmi = 0; step();
      // maskable INT accepted
      r_iffx_we = 1; r_iffx_bit = 1; step();
      idle(); r_intr = 1; r_m1 = 1; step();
      // INT refused with iff1=0, then with ctl_no_ints
      idle(); r_m1 = 1; step();
      r_iffx_we = 1; r_iffx_bit = 1; r_m1 = 0; step();
      idle(); r_m1 = 1; r_no_ints = 1; step();
      // NMI and INT together
      idle(); r_nmi = 1; r_m1 = 1; step();
      r_intr = 0; r_nmi = 0; step();
      // pending NMI blocked by ctl_no_ints, taken later; held nmi level does not retrigger
      r_nmi = 1; step();
      r_m1 = 1; r_no_ints = 1; step();
      idle(); step();
      r_m1 = 1; step();
      r_m1 = 1; step();
      // reset mid-sequence discards pending NMI
      idle(); r_nmi = 0; step(); r_nmi = 1; step();
      r_nreset = 0; step();
      idle(); r_nmi = 0; r_m1 = 1; step();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r_nreset   = ($urandom_range(0, 149) != 0);
         r_im_we    = ($urandom_range(0, 7) == 0);
         r_db       = 2'($urandom);
         r_iffx_we  = ($urandom_range(0, 3) == 0);
         r_iffx_bit = ($urandom_range(0, 3) != 0);
         r_i12      = ($urandom_range(0, 9) == 0);
         r_no_ints  = ($urandom_range(0, 3) == 0);
         r_m1       = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 5) == 0) r_nmi = ~r_nmi;
         if ($urandom_range(0, 3) == 0) r_intr = ~r_intr;
         step();
      end

      idle(); step();
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
